deserializer: RTL
=================

Name: deserializer

Overview:
- Receiving end of the team's serial bit-stream link: collects MSB-first serial bits qualified by a valid strobe into parallel words of up to DATA_W bits.
- A burst is a run of consecutive cycles with ser_data_val_i high. Each burst of 1..DATA_W bits produces one parallel word plus its bit count.
- Length encoding matches the transmit side's data_mod convention: 0 means a full DATA_W-bit word.

Parameters:
- DATA_W, 16: maximum word width in bits; must be a power of two, at least 2.
- LEN_W, $clog2(DATA_W): width of the length field; derived, do not override.

Ports:
- clk_i  input  1  clock
- srst_i  input  1  synchronous active-high reset
- ser_data_i  input  1  serial data bit, MSB of the word first
- ser_data_val_i  input  1  ser_data_i valid this cycle
- deser_data_o  output  DATA_W  received word, left-aligned; unused LSBs are 0
- deser_len_o  output  LEN_W  number of bits received; 0 means DATA_W
- deser_data_val_o  output  1  one-cycle strobe qualifying deser_data_o and deser_len_o
- busy_o  output  1  a burst is partially collected

Behaviour:
- Clock and reset
  - One clock domain, clk_i.
  - Reset is synchronous and active-high on srst_i; everything samples on the rising edge of clk_i.
- Reset values (the cycle after srst_i is sampled high)
  - deser_data_o = 0, deser_len_o = 0, deser_data_val_o = 0, busy_o = 0.
  - Shift register = 0, bit counter = 0.
- Internal state: shift register sh[DATA_W-1:0] and bit counter cnt, range 0..DATA_W-1, width LEN_W.
- Bit capture, on each cycle with ser_data_val_i = 1:
  - sh[DATA_W-1-cnt] <= ser_data_i.
  - cnt increments.
- Full word: when cnt == DATA_W-1 and a valid bit arrives, on the next edge:
  - deser_data_o = the completed word (including this bit).
  - deser_len_o = 0 and deser_data_val_o = 1.
  - cnt returns to 0 and sh clears.
  - Latency is 1 cycle after the last bit.
- Back-to-back full words: if ser_data_val_i stays high, the next bit is bit 0 of a new word. The same cycle that outputs word N also captures the first bit of word N+1, with no lost bits. A continuous stream therefore yields one strobe per DATA_W cycles.
- Partial word: when ser_data_val_i = 0 and cnt = k with k ≥ 1, on the next edge:
  - deser_data_o = sh (k MSBs valid, rest 0).
  - deser_len_o = k and deser_data_val_o = 1.
  - cnt returns to 0 and sh clears.
  - Latency is 2 cycles after the last bit: one cycle for the gap, one for the register.
- Idle: ser_data_val_i = 0 with cnt = 0 produces no strobe.
- deser_data_val_o
  - High for exactly one cycle per emitted word.
  - deser_data_o and deser_len_o hold their last value while the strobe is low.
- busy_o is registered; it is 1 in every cycle where cnt ≠ 0.
- State machine
  - IDLE (cnt = 0) goes to COLLECT on a valid bit.
  - COLLECT goes to IDLE, with an emit, on the DATA_W-th bit or on a gap.
  - The emit is a registered output; there is no separate state.
- Reset mid-burst
  - Partial data is discarded and no strobe is produced.
  - An output strobe pending for the same edge is suppressed.
  - srst_i overrides all other events.
- No backpressure: the consumer must accept every strobe.

Optional Feature:
- Macro: DESER_DROP_PARTIAL_EN
- Defined:
  - A burst ending with cnt < DATA_W is discarded silently: cnt and sh clear, no strobe.
  - Only full words are emitted, and deser_len_o is always 0.
  - busy_o behaves the same as without the macro.
- Undefined: partial words are emitted as described in Behaviour.

Test Plan:
- Reset, then 16 continuous valid bits of 0xA5C3 MSB-first -> one cycle after the 16th bit: deser_data_o = 0xA5C3, deser_len_o = 0, one-cycle strobe. busy_o is high for bits 2..16 cycles and low after.
- 32 continuous valid bits carrying 0x1234 then 0xFFFF -> two strobes exactly 16 cycles apart with 0x1234 and 0xFFFF; no bit lost at the boundary.
- 5-bit burst 1,0,1,1,0, then val low -> strobe 2 cycles after the last bit with deser_data_o = 0xB000 and deser_len_o = 5. With DESER_DROP_PARTIAL_EN: no strobe, busy_o returns to 0.
- 1-bit burst of 1 -> deser_data_o = 0x8000, deser_len_o = 1. Then 20 idle cycles -> no further strobes, outputs hold.
- 9 valid bits, srst_i high for 1 cycle, then 16 bits of 0x0F0F -> no strobe for the aborted burst; single strobe with 0x0F0F, deser_len_o = 0.
- Assert srst_i on the same edge as the 16th bit of a word -> no strobe; all outputs 0 the following cycle.

Source files
------------

// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
//
// Purpose:
//   This is the receive side of the serial bit-stream link. It collects serial
//   bits that arrive MSB-first, each qualified by ser_data_val_i, and packs
//   them into left-aligned parallel words of up to DATA_W bits.
//
//   A burst is a run of consecutive valid cycles. Each burst produces one
//   output word, and a burst longer than DATA_W produces back-to-back full
//   words. The length field uses the transmit side's data_mod encoding, in
//   which 0 means a full DATA_W-bit word.
//
// Configuration:
//   DESER_DROP_PARTIAL_EN (macro)
//     When defined, a burst that ends before DATA_W bits is discarded
//     silently. Only full words are emitted, so deser_len_o is always 0.
//
// Ports:
//   clk_i             clock
//   srst_i            synchronous active-high reset (overrides everything)
//   ser_data_i        serial data bit, word MSB first
//   ser_data_val_i    ser_data_i valid this cycle
//   deser_data_o      received word, left-aligned, unused LSBs are 0
//   deser_len_o       number of bits received (0 means DATA_W)
//   deser_data_val_o  one-cycle strobe qualifying deser_data_o/deser_len_o
//   busy_o            a burst is partially collected (bit counter != 0)
// -----------------------------------------------------------------------------
module deserializer #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [LEN_W-1:0]  deser_len_o,
  output logic              deser_data_val_o,
  output logic              busy_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                val_q, val_d;
  logic                busy_q, busy_d;

  // Shift register with the incoming bit already placed. The full-word emit
  // uses this value so that the last bit lands in the same-edge output.
  logic [DATA_W-1:0]   sh_cap;
  logic [LEN_W-1:0]    bit_idx;

  always_comb begin
    bit_idx = LAST_IDX - cnt_q;
    sh_cap  = sh_q;
    sh_cap[bit_idx] = ser_data_i;

    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    len_d   = len_q;
    val_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // DATA_W >= 2, so the first bit of a burst can never complete a word.
        if (ser_data_val_i) begin
          sh_d    = sh_cap;
          cnt_d   = cnt_q + LEN_W'(1);
          state_d = COLLECT;
        end
      end

      COLLECT: begin
        if (ser_data_val_i) begin
          if (cnt_q == LAST_IDX) begin
            // The word is complete. The register clears, so a bit that
            // arrives on the next cycle starts a new word with nothing lost.
            data_d  = sh_cap;
            len_d   = '0;
            val_d   = 1'b1;
            cnt_d   = '0;
            sh_d    = '0;
            state_d = IDLE;
          end else begin
            sh_d  = sh_cap;
            cnt_d = cnt_q + LEN_W'(1);
          end
        end else begin
          // A gap ends the burst early.
`ifdef DESER_DROP_PARTIAL_EN
          cnt_d   = '0;
          sh_d    = '0;
          state_d = IDLE;
`else
          data_d  = sh_q;
          len_d   = cnt_q;
          val_d   = 1'b1;
          cnt_d   = '0;
          sh_d    = '0;
          state_d = IDLE;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sh_d    = '0;
      end
    endcase

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      len_q   <= '0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      len_q   <= len_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
    end
  end

  assign deser_data_o     = data_q;
  assign deser_len_o      = len_q;
  assign deser_data_val_o = val_q;
  assign busy_o           = busy_q;

endmodule
